// File: rtl/windowed_reg_file.sv
// SPARC-style windowed register file: 8 globals plus NWIN overlapping 16-register windows selected by CWP.
// Define WB_BYPASS_EN to forward same-cycle write data to the read ports.
module windowed_reg_file #(
  parameter int DATA_W = 32,
  parameter int NWIN   = 8,
  localparam int CWP_W = $clog2(NWIN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        dest_reg,
  input  logic [DATA_W-1:0] value_to_write,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              save,
  input  logic              restore,
  input  logic              wim_wr_en,
  input  logic [NWIN-1:0]   wim_wr_data,
  output logic [CWP_W-1:0]  cwp,
  output logic [NWIN-1:0]   wim,
  output logic              ovf_trap,
  output logic              unf_trap
);

  localparam int NREGS  = 8 + 16 * NWIN;
  localparam int PHYS_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [PHYS_W-1:0] wr_phys;
  logic [PHYS_W-1:0] rd_phys_a;
  logic [PHYS_W-1:0] rd_phys_b;
  logic [CWP_W-1:0]  cwp_dec;
  logic [CWP_W-1:0]  cwp_inc;
  logic              wr_hit;

  // Outs of window w live in the ins of window w-1, which is what makes SAVE pass arguments.
  function automatic logic [PHYS_W-1:0] phys_index(input logic [4:0] r, input logic [CWP_W-1:0] w);
    int idx;
    int wm1;
    wm1 = (w == '0) ? (NWIN - 1) : (int'(w) - 1);
    case (r[4:3])
      2'd0:    idx = int'(r[2:0]);
      2'd1:    idx = 16 + 16 * wm1 + int'(r[2:0]);
      2'd2:    idx = 8 + 16 * int'(w) + int'(r[2:0]);
      default: idx = 16 + 16 * int'(w) + int'(r[2:0]);
    endcase
    return PHYS_W'(idx);
  endfunction

  assign cwp_dec   = (cwp == '0) ? CWP_W'(NWIN - 1) : cwp - CWP_W'(1);
  assign cwp_inc   = (cwp == CWP_W'(NWIN - 1)) ? '0 : cwp + CWP_W'(1);
  assign wr_hit    = wr_en && (dest_reg != 5'd0);
  assign wr_phys   = phys_index(dest_reg, cwp);
  assign rd_phys_a = phys_index(rd_addr_a, cwp);
  assign rd_phys_b = phys_index(rd_addr_b, cwp);

  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != 5'd0) begin
      rd_data_a = regs[rd_phys_a];
`ifdef WB_BYPASS_EN
      if (wr_hit && (rd_phys_a == wr_phys)) rd_data_a = value_to_write;
`endif
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != 5'd0) begin
      rd_data_b = regs[rd_phys_b];
`ifdef WB_BYPASS_EN
      if (wr_hit && (rd_phys_b == wr_phys)) rd_data_b = value_to_write;
`endif
    end
  end

  // The write uses the pre-edge CWP, and window checks use the pre-edge WIM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      cwp      <= '0;
      wim      <= '0;
      ovf_trap <= 1'b0;
      unf_trap <= 1'b0;
    end else begin
      ovf_trap <= 1'b0;
      unf_trap <= 1'b0;
      if (wr_hit) regs[wr_phys] <= value_to_write;
      if (wim_wr_en) wim <= wim_wr_data;
      if (save && !restore) begin
        if (wim[cwp_dec]) ovf_trap <= 1'b1;
        else              cwp      <= cwp_dec;
      end else if (restore && !save) begin
        if (wim[cwp_inc]) unf_trap <= 1'b1;
        else              cwp      <= cwp_inc;
      end
    end
  end

endmodule

// File: tb/tb_windowed_reg_file.sv
// Directed bench for windowed_reg_file (NWIN=8): expectations are queued as stimulus is driven and popped at each check.
module tb_windowed_reg_file;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  dest_reg;
  logic [31:0] value_to_write;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        save;
  logic        restore;
  logic        wim_wr_en;
  logic [7:0]  wim_wr_data;
  logic [2:0]  cwp;
  logic [7:0]  wim;
  logic        ovf_trap;
  logic        unf_trap;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  windowed_reg_file #(.DATA_W(32), .NWIN(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .dest_reg(dest_reg),
    .value_to_write(value_to_write), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .save(save), .restore(restore),
    .wim_wr_en(wim_wr_en), .wim_wr_data(wim_wr_data), .cwp(cwp), .wim(wim),
    .ovf_trap(ovf_trap), .unf_trap(unf_trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic pushExpect(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard-empty observed=%0h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] val);
    pushExpect(tag, val);
    checkOutput(obs);
  endtask

  // Drives one clock's worth of inputs, waits for the edge, then drops the strobes.
  task automatic applyStimulus(input logic we, input logic [4:0] d, input logic [31:0] v,
                               input logic sv, input logic rs,
                               input logic ww, input logic [7:0] wd);
    wr_en = we; dest_reg = d; value_to_write = v;
    save = sv; restore = rs; wim_wr_en = ww; wim_wr_data = wd;
    @(posedge clk);
    #1;
    wr_en = 1'b0; save = 1'b0; restore = 1'b0; wim_wr_en = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [4:0] a, input logic [31:0] val);
    rd_addr_a = a;
    #1;
    check(tag, rd_data_a, val);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; wr_en = 1'b0; dest_reg = '0; value_to_write = '0;
    rd_addr_a = '0; rd_addr_b = '0; save = 1'b0; restore = 1'b0;
    wim_wr_en = 1'b0; wim_wr_data = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    check("reset_cwp", 32'(cwp), 0);
    check("reset_wim", 32'(wim), 0);
    check("reset_ovf", 32'(ovf_trap), 0);
    check("reset_unf", 32'(unf_trap), 0);
    readCheck("reset_r5", 5'd5, 0);

    // Fill r1..r31 at CWP=0, read both ports back.
    for (int n = 1; n < 32; n++) applyStimulus(1, 5'(n), 32'(100 * n), 0, 0, 0, 0);
    for (int n = 0; n < 32; n++) begin
      rd_addr_a = 5'(n);
      rd_addr_b = 5'(31 - n);
      #1;
      check("fill_port_a", rd_data_a, 32'(100 * n));
      check("fill_port_b", rd_data_b, 32'(100 * (31 - n)));
    end
    applyStimulus(1, 5'd0, 32'd999, 0, 0, 0, 0);
    readCheck("r0_discard", 5'd0, 0);

    // Outs of window 0 become ins of window 7 after SAVE.
    applyStimulus(1, 5'd8, 32'hAAAA, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    check("save_wrap_cwp", 32'(cwp), 7);
    readCheck("alias_r24", 5'd24, 32'hAAAA);
    readCheck("win7_r16", 5'd16, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    check("restore_wrap_cwp", 32'(cwp), 0);
    readCheck("alias_r8", 5'd8, 32'hAAAA);

    // Overflow/underflow traps against WIM.
    applyStimulus(0, 0, 0, 0, 0, 1, 8'b1000_0000);
    check("wim_load", 32'(wim), 32'h80);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    check("ovf_pulse", 32'(ovf_trap), 1);
    check("ovf_cwp", 32'(cwp), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    check("ovf_drop", 32'(ovf_trap), 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 8'b0000_0010);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    check("unf_pulse1", 32'(unf_trap), 1);
    check("unf_cwp", 32'(cwp), 0);
    check("unf_no_ovf", 32'(ovf_trap), 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    check("unf_pulse2", 32'(unf_trap), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    check("unf_drop", 32'(unf_trap), 0);

    // Same-cycle WIM load and SAVE: the old WIM (0x02) is checked, so window 7 is allowed.
    applyStimulus(0, 0, 0, 1, 0, 1, 8'b1000_0000);
    check("old_wim_cwp", 32'(cwp), 7);
    check("old_wim_ovf", 32'(ovf_trap), 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 8'h00);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    check("back_to_0", 32'(cwp), 0);

    // Eight SAVEs walk the full ring.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      check("ring_cwp", 32'(cwp), 32'((7 - k) & 7));
      check("ring_ovf", 32'(ovf_trap), 0);
    end
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    check("both_cwp", 32'(cwp), 0);
    check("both_ovf", 32'(ovf_trap), 0);
    check("both_unf", 32'(unf_trap), 0);

    // Write with SAVE on the same edge lands in the pre-save window.
    applyStimulus(1, 5'd16, 32'h1234, 1, 0, 0, 0);
    check("wsave_cwp", 32'(cwp), 7);
    readCheck("wsave_win7_r16", 5'd16, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    readCheck("wsave_r16", 5'd16, 32'h1234);

    // Same-cycle write/read of r5.
    applyStimulus(1, 5'd5, 32'h11, 0, 0, 0, 0);
    wr_en = 1'b1; dest_reg = 5'd5; value_to_write = 32'h55;
`ifdef WB_BYPASS_EN
    readCheck("bypass_r5", 5'd5, 32'h55);
`else
    readCheck("bypass_r5", 5'd5, 32'h11);
`endif
    applyStimulus(1, 5'd5, 32'h55, 0, 0, 0, 0);
    readCheck("after_r5", 5'd5, 32'h55);

    // Reset beats a simultaneous write, save and WIM load.
    reset = 1'b1;
    applyStimulus(1, 5'd6, 32'h77, 1, 0, 1, 8'hFF);
    reset = 1'b0;
    readCheck("rst_r6", 5'd6, 0);
    readCheck("rst_r1", 5'd1, 0);
    check("rst_cwp", 32'(cwp), 0);
    check("rst_wim", 32'(wim), 0);
    check("rst_ovf", 32'(ovf_trap), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
